caf_peak_select: RTL and testbench

Peak selector for the CAF pipeline, directly downstream of the argmax stage. The argmax stage emits one (magnitude, time index) result per frequency-shift bin. This block consumes `freq_bins` of those results and reports the global CAF peak for the frame: its magnitude, its time index, and its frequency-bin index. The result is then released on a valid/ready handshake to the host/readout stage.

---
 rtl/caf_peak_select.sv | 114 +++++++++++
 tb/tb_caf_peak_select.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_select.sv
// caf_peak_select: reports the global CAF peak (magnitude, time index, frequency bin) over freq_bins argmax results.
// Optional macro CAF_PEAK_THRESHOLD_EN adds a threshold input and a registered peak_detect flag.
module caf_peak_select #(
    parameter int max_bits        = 32,
    parameter int index_bits      = 10,
    parameter int freq_bins       = 4,
    parameter int freq_index_bits = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [max_bits-1:0]        in_max,
    input  logic [index_bits-1:0]      in_index,
    output logic                       s_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [max_bits-1:0]        peak_max,
    output logic [index_bits-1:0]      peak_index,
    output logic [freq_index_bits-1:0] peak_freq
`ifdef CAF_PEAK_THRESHOLD_EN
    ,
    input  logic [max_bits-1:0]        threshold,
    output logic                       peak_detect
`endif
);

    typedef enum logic {ACCUM, HOLD} state_e;

    localparam logic [freq_index_bits-1:0] LastBin = freq_index_bits'(freq_bins - 1);

    state_e                     state_q;
    logic                       valid_q;
    logic [freq_index_bits-1:0] bin_cnt_q;
    logic [max_bits-1:0]        peak_max_q,   peak_max_d;
    logic [index_bits-1:0]      peak_index_q, peak_index_d;
    logic [freq_index_bits-1:0] peak_freq_q,  peak_freq_d;
    logic                       in_xfer;
    logic                       take_new;

    assign in_xfer  = m_axis_tvalid && (state_q == ACCUM);
    // Bin 0 seeds the frame; later bins win only on a strict increase, so ties keep the earlier bin.
    assign take_new = (bin_cnt_q == '0) || (in_max > peak_max_q);

    always_comb begin
        peak_max_d   = peak_max_q;
        peak_index_d = peak_index_q;
        peak_freq_d  = peak_freq_q;
        if (in_xfer && take_new) begin
            peak_max_d   = in_max;
            peak_index_d = in_index;
            peak_freq_d  = bin_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            valid_q      <= 1'b0;
            bin_cnt_q    <= '0;
            peak_max_q   <= '0;
            peak_index_q <= '0;
            peak_freq_q  <= '0;
        end else begin
            peak_max_q   <= peak_max_d;
            peak_index_q <= peak_index_d;
            peak_freq_q  <= peak_freq_d;
            case (state_q)
                ACCUM: begin
                    if (m_axis_tvalid) begin
                        if (bin_cnt_q == LastBin) begin
                            bin_cnt_q <= '0;
                            state_q   <= HOLD;
                            valid_q   <= 1'b1;
                        end else begin
                            bin_cnt_q <= bin_cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_axis_tready) begin
                        state_q <= ACCUM;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAF_PEAK_THRESHOLD_EN
    logic peak_detect_q;

    // The detect flag is judged against the final peak, captured on the same edge that enters HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_detect_q <= 1'b0;
        end else if (in_xfer && (bin_cnt_q == LastBin)) begin
            peak_detect_q <= (peak_max_d > threshold);
        end
    end

    assign peak_detect = peak_detect_q;
`endif

    assign s_axis_tready = (state_q == ACCUM);
    assign s_axis_tvalid = valid_q;
    assign peak_max      = peak_max_q;
    assign peak_index    = peak_index_q;
    assign peak_freq     = peak_freq_q;

endmodule

// File: tb/tb_caf_peak_select.sv
// tb_caf_peak_select: directed and randomized checks of caf_peak_select against a frame-level reference model.
// Define CAF_PEAK_THRESHOLD_EN consistently for bench and design to cover the threshold feature.
module tb_caf_peak_select;

    localparam int MAXB  = 32;
    localparam int IDXB  = 10;
    localparam int BINS  = 4;
    localparam int FREQB = 2;

    logic             clk;
    logic             rst_n;
    logic             m_axis_tvalid;
    logic             s_axis_tready;
    logic [MAXB-1:0]  in_max;
    logic [IDXB-1:0]  in_index;
    logic             s_axis_tvalid;
    logic             m_axis_tready;
    logic [MAXB-1:0]  peak_max;
    logic [IDXB-1:0]  peak_index;
    logic [FREQB-1:0] peak_freq;
`ifdef CAF_PEAK_THRESHOLD_EN
    logic [MAXB-1:0]  threshold;
    logic             peak_detect;
`endif

    int compared   = 0;
    int mismatched = 0;

    caf_peak_select #(
        .max_bits(MAXB), .index_bits(IDXB), .freq_bins(BINS), .freq_index_bits(FREQB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_axis_tvalid(m_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .in_max(in_max),
        .in_index(in_index),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .peak_max(peak_max),
        .peak_index(peak_index),
        .peak_freq(peak_freq)
`ifdef CAF_PEAK_THRESHOLD_EN
        ,
        .threshold(threshold),
        .peak_detect(peak_detect)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: the frame is the list of bins accepted so far; the visible peak is its first maximum.
    logic [MAXB-1:0] qMax[$];
    logic [IDXB-1:0] qIdx[$];
    logic [MAXB-1:0] expMax;
    logic [IDXB-1:0] expIdx;
    int              expFreq;
    bit              expHold;
    bit              expDetect;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qMax.delete();
            qIdx.delete();
            expMax    = '0;
            expIdx    = '0;
            expFreq   = 0;
            expHold   = 1'b0;
            expDetect = 1'b0;
        end else if (expHold) begin
            if (m_axis_tready) expHold = 1'b0;
        end else if (m_axis_tvalid) begin
            qMax.push_back(in_max);
            qIdx.push_back(in_index);
            foreach (qMax[i]) begin
                if (i == 0 || qMax[i] > expMax) begin
                    expMax  = qMax[i];
                    expIdx  = qIdx[i];
                    expFreq = i;
                end
            end
            if (qMax.size() == BINS) begin
                expHold = 1'b1;
`ifdef CAF_PEAK_THRESHOLD_EN
                expDetect = (expMax > threshold);
`endif
                qMax.delete();
                qIdx.delete();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.s_axis_tready", 64'(s_axis_tready), 64'(!expHold));
        checkOutput("model.s_axis_tvalid", 64'(s_axis_tvalid), 64'(expHold));
        checkOutput("model.peak_max",      64'(peak_max),      64'(expMax));
        checkOutput("model.peak_index",    64'(peak_index),    64'(expIdx));
        checkOutput("model.peak_freq",     64'(peak_freq),     64'(expFreq));
`ifdef CAF_PEAK_THRESHOLD_EN
        checkOutput("model.peak_detect",   64'(peak_detect),   64'(expDetect));
`endif
    end

    // Offers one bin after 'gap' idle cycles and holds it until accepted; 'waited' counts edges until acceptance.
    task automatic applyStimulus(input logic [MAXB-1:0] mx, input logic [IDXB-1:0] ix,
                                 input int gap, output int waited);
        bit acc;
        m_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
        in_max        = mx;
        in_index      = ix;
        m_axis_tvalid = 1'b1;
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #2;
            waited++;
        end
        m_axis_tvalid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 64'(waited), 64'(0));
    endtask

    task automatic sendFrame(input logic [MAXB-1:0] m0, input logic [IDXB-1:0] i0,
                             input logic [MAXB-1:0] m1, input logic [IDXB-1:0] i1,
                             input logic [MAXB-1:0] m2, input logic [IDXB-1:0] i2,
                             input logic [MAXB-1:0] m3, input logic [IDXB-1:0] i3,
                             input int gap);
        int w;
        applyStimulus(m0, i0, gap, w);
        applyStimulus(m1, i1, gap, w);
        applyStimulus(m2, i2, gap, w);
        applyStimulus(m3, i3, gap, w);
    endtask

    task automatic checkPeak(input string tag, input logic [MAXB-1:0] m,
                             input logic [IDXB-1:0] ix, input int f);
        checkOutput({tag, ".s_axis_tvalid"}, 64'(s_axis_tvalid), 64'(1));
        checkOutput({tag, ".peak_max"},      64'(peak_max),      64'(m));
        checkOutput({tag, ".peak_index"},    64'(peak_index),    64'(ix));
        checkOutput({tag, ".peak_freq"},     64'(peak_freq),     64'(f));
    endtask

    initial begin
        int  w;
        bit  wasReady;
        rst_n         = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        in_max        = '0;
        in_index      = '0;
`ifdef CAF_PEAK_THRESHOLD_EN
        threshold     = MAXB'(8);
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset.s_axis_tready", 64'(s_axis_tready), 64'(1));
        checkOutput("reset.s_axis_tvalid", 64'(s_axis_tvalid), 64'(0));
        checkOutput("reset.peak_max",      64'(peak_max),      64'(0));
        checkOutput("reset.peak_freq",     64'(peak_freq),     64'(0));
        @(posedge clk);
        #2;

        sendFrame(5, 3, 9, 7, 2, 1, 8, 0, 0);
        @(negedge clk);
        checkPeak("basic", 9, 7, 1);
`ifdef CAF_PEAK_THRESHOLD_EN
        checkOutput("basic.peak_detect", 64'(peak_detect), 64'(1));
`endif
        @(posedge clk);
        #2;

        sendFrame(6, 2, 6, 4, 6, 5, 1, 0, 0);
        @(negedge clk);
        checkPeak("tie", 6, 2, 0);
        @(posedge clk);
        #2;

        applyStimulus(3, 1, 0, w);
        m_axis_tready = 1'b0;
        applyStimulus(12, 5, 0, w);
        applyStimulus(12, 6, 0, w);
        applyStimulus(7, 2, 0, w);
        in_max        = 20;
        in_index      = 11;
        m_axis_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp.s_axis_tready", 64'(s_axis_tready), 64'(0));
            checkPeak("bp", 12, 5, 1);
            @(posedge clk);
            #2;
        end
        m_axis_tready = 1'b1;
        applyStimulus(20, 11, 0, w);
        checkOutput("bp.accept_edges", 64'(w), 64'(2));
        applyStimulus(1, 0, 0, w);
        applyStimulus(2, 0, 0, w);
        applyStimulus(3, 0, 0, w);
        @(negedge clk);
        checkPeak("bp_next", 20, 11, 0);
        @(posedge clk);
        #2;

        applyStimulus(1, 0, 1, w);
        applyStimulus(3, 1, 1, w);
        applyStimulus(10, 9, 1, w);
        @(negedge clk);
        checkOutput("gap.early_valid", 64'(s_axis_tvalid), 64'(0));
        @(posedge clk);
        #2;
        applyStimulus(4, 4, 1, w);
        @(negedge clk);
        checkPeak("gap", 10, 9, 2);
        @(posedge clk);
        #2;

        applyStimulus(50, 1, 0, w);
        applyStimulus(60, 2, 0, w);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.s_axis_tvalid", 64'(s_axis_tvalid), 64'(0));
        checkOutput("abort.peak_max",      64'(peak_max),      64'(0));
        @(posedge clk);
        #2;
        sendFrame(1, 1, 2, 2, 3, 3, 4, 4, 0);
        @(negedge clk);
        checkPeak("abort", 4, 4, 3);
        @(posedge clk);
        #2;

        sendFrame(8, 1, 3, 2, 0, 0, 7, 3, 0);
        @(negedge clk);
        checkPeak("thr_equal", 8, 1, 0);
`ifdef CAF_PEAK_THRESHOLD_EN
        checkOutput("thr_equal.peak_detect", 64'(peak_detect), 64'(0));
`endif
        @(posedge clk);
        #2;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wasReady = s_axis_tready;
            @(posedge clk);
            #2;
            if (c == 1500) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            if (!m_axis_tvalid || wasReady || c == 1500) begin
                m_axis_tvalid = ($urandom_range(0, 3) != 0);
                in_max        = ($urandom_range(0, 1) != 0) ? MAXB'($urandom_range(0, 15)) : MAXB'($urandom);
                in_index      = IDXB'($urandom);
            end
            m_axis_tready = ($urandom_range(0, 2) != 0);
`ifdef CAF_PEAK_THRESHOLD_EN
            threshold     = ($urandom_range(0, 1) != 0) ? MAXB'($urandom_range(0, 15)) : MAXB'($urandom);
`endif
        end
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
